// File: rtl/comparador_serial_ctrl.sv
// comparador_serial_ctrl
// Bit-serial A <= B comparator. One comparison cell is reused across up to
// N clock cycles, scanning the latched operands from MSB to LSB.
// Zout = 1 means A <= B, Zout = 0 means A > B.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start; operands captured on the accepting edge
// S_COMPARE | one bit per clock, MSB first; exits on idx = 0 or early hit
// S_DONE    | one-cycle done pulse; start is ignored here
module comparador_serial_ctrl #(
  parameter int N          = 4,
  parameter bit EARLY_EXIT = 1'b1,
  parameter int CW         = $clog2(N + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [N-1:0]  A,
  input  logic [N-1:0]  B,
  output logic          busy,
  output logic          done,
  output logic          Zout,
  output logic [CW-1:0] ciclos
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    REL_EQ = 2'd0,
    REL_LT = 2'd1,
    REL_GT = 2'd2
  } rel_t;

  state_t        r_state;
  rel_t          r_rel;
  logic [N-1:0]  r_ra;
  logic [N-1:0]  r_rb;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] r_cnt;
  logic          r_busy;
  logic          r_done;
  logic          r_zout;
  logic [CW-1:0] r_ciclos;

  logic          w_bit_a;
  logic          w_bit_b;
  rel_t          w_rel_next;
  logic          w_exit;
  logic [CW-1:0] w_cnt_inc;

  assign w_bit_a   = r_ra[r_idx];
  assign w_bit_b   = r_rb[r_idx];
  assign w_cnt_inc = r_cnt + CW'(1);

  // Comparison cell: the first differing bit decides, later bits cannot change it.
  always_comb begin
    w_rel_next = r_rel;
    if (r_rel == REL_EQ) begin
      if (!w_bit_a && w_bit_b) begin
        w_rel_next = REL_LT;
      end else if (w_bit_a && !w_bit_b) begin
        w_rel_next = REL_GT;
      end
    end
  end

  // Leave the scan at the LSB, or as soon as the relation is decided when early exit is on.
  always_comb begin
    w_exit = (r_idx == '0) || ((EARLY_EXIT != 1'b0) && (w_rel_next != REL_EQ));
  end

  // Sequencer: operand capture, per-bit scan and registered handshake/result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_rel    <= REL_EQ;
      r_ra     <= '0;
      r_rb     <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_zout   <= 1'b0;
      r_ciclos <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_ra    <= A;
            r_rb    <= B;
            r_rel   <= REL_EQ;
            r_idx   <= IW'(N - 1);
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_COMPARE;
          end
        end
        S_COMPARE: begin
          r_cnt <= w_cnt_inc;
          r_rel <= w_rel_next;
          if (w_exit) begin
            r_state  <= S_DONE;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_zout   <= (w_rel_next != REL_GT);
            r_ciclos <= w_cnt_inc;
          end else begin
            r_idx <= r_idx - IW'(1);
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign Zout   = r_zout;
  assign ciclos = r_ciclos;

endmodule
